// File: rtl/ps2_key_event.sv
// ---------------------------------------------------------------------------
// ps2_key_event
//
// Turns the raw PS/2 keyboard clock/data lines into the 11-bit toggle-strobed
// key event word consumed by core input decoders.
//
// Event word: {toggle, pressed, extended, code[7:0]}. Consumers detect a new
// event by watching bit 10 change.
//
// Ports:
//   clk_sys      in   system clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   ps2_clk_in   in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  in   raw PS/2 data line (asynchronous)
//   ps2_key      out  event word
//   frame_err    out  one-cycle pulse when a frame is discarded
//                     (parity, stop bit or inter-bit timeout)
//   busy         out  frame in progress or prefix/pause sequence pending
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_key_event #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 11000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]  FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

    // Two-stage synchronizers; index 1 is the synchronized value.
    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;

    logic          filt_clk_q,  filt_clk_d;
    logic [7:0]    filt_cnt_q,  filt_cnt_d;
    logic [3:0]    bit_cnt_q,   bit_cnt_d;
    logic [8:0]    shift_q,     shift_d;     // {parity, d7..d0} once full
    logic [TW-1:0] to_cnt_q,    to_cnt_d;
    logic          ext_q,       ext_d;
    logic          brk_q,       brk_d;
    logic [2:0]    pause_q,     pause_d;
    logic [10:0]   key_q,       key_d;
    logic          err_q,       err_d;

    logic          fall;
    logic          data_s;
    logic [7:0]    rx_byte;

    assign data_s  = data_sync_q[1];
    assign rx_byte = shift_q[7:0];

    // Clock glitch filter: the filtered clock only follows the synchronized
    // clock after it has disagreed for FILTER_LEN consecutive cycles. The
    // falling edge is flagged in the same cycle the filtered value drops.
    always_comb begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_sync_q[1] != filt_clk_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_clk_d = clk_sync_q[1];
                fall       = filt_clk_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end
    end

    // Frame receive, timeout recovery and byte decode.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        pause_d   = pause_q;
        key_d     = key_q;
        err_d     = 1'b0;

        if (fall) begin
            // An edge always wins over a coincident timeout.
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A high "start bit" is noise; stay idle.
                if (!data_s) begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q != 4'd10) begin
                shift_d   = {data_s, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                bit_cnt_d = 4'd0;
                // Odd parity: XOR over data and parity bit must be 1.
                if (!(data_s && (^shift_q))) begin
                    err_d   = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                    pause_d = 3'd0;
                end else if (pause_q != 3'd0) begin
                    // Swallow the remainder of the Pause key sequence.
                    pause_d = pause_q - 3'd1;
                end else if (rx_byte == 8'hE1) begin
                    pause_d = 3'd7;
                end else if (rx_byte == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (rx_byte == 8'hF0) begin
                    brk_d = 1'b1;
                end else if (rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                             8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
                    // Keyboard status/acknowledge bytes, not keys.
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end else begin
                    key_d = {~key_q[10], ~brk_q, ext_q, rx_byte};
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_MAX) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
                err_d     = 1'b1;
                ext_d     = 1'b0;
                brk_d     = 1'b0;
                pause_d   = 3'd0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_clk_q  <= 1'b1;
            filt_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            pause_q     <= '0;
            key_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            filt_clk_q  <= filt_clk_d;
            filt_cnt_q  <= filt_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            to_cnt_q    <= to_cnt_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            pause_q     <= pause_d;
            key_q       <= key_d;
            err_q       <= err_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = (bit_cnt_q != 4'd0) | ext_q | brk_q | (pause_q != 3'd0);

endmodule

// File: tb/tb_ps2_key_event.sv
`timescale 1ns/1ps

module tb_ps2_key_event;

    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 16;   // PS/2 half bit period in clk_sys cycles
    localparam int GAP  = 24;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk_in = 1'b1;
    logic        ps2_data_in = 1'b1;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    ps2_key_event #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_key     (ps2_key),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          err;
        logic [10:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state (keyboard protocol level).
    bit          m_ext, m_brk;
    int          m_pause;
    logic [10:0] m_key;

    logic [10:0] prev_key = '0;
    longint      t_fall = 0;
    bit          check_to = 1'b0;

    function automatic bit is_status(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
               (b >= 8'hFC);
    endfunction

    function automatic void model_clear();
        m_ext = 0; m_brk = 0; m_pause = 0;
    endfunction

    function automatic void push_err();
        exp_t e;
        e.err = 1'b1; e.key = '0;
        exp_q.push_back(e);
    endfunction

    // Expected effect of one received frame.
    function automatic void model_frame(input logic [7:0] b, input bit good);
        exp_t e;
        if (!good) begin
            push_err();
            model_clear();
        end else if (m_pause > 0) begin
            m_pause--;
        end else if (b == 8'hE1) begin
            m_pause = 7;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (is_status(b)) begin
            m_ext = 0; m_brk = 0;
        end else begin
            m_key = {~m_key[10], ~m_brk, m_ext, b};
            e.err = 1'b0; e.key = m_key;
            exp_q.push_back(e);
            m_ext = 0; m_brk = 0;
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_sys);
    endtask

    // Drive the first nbits of a frame; optional short glitch after bit glitch_at.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = (~^b) ^ bad_par;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data_in = bits[i];
            wait_cyc(HALF);
            ps2_clk_in = 1'b0;
            t_fall = $time;
            wait_cyc(HALF);
            ps2_clk_in = 1'b1;
            if (i == glitch_at) begin
                wait_cyc(HALF);
                ps2_clk_in = 1'b0;
                wait_cyc(FL - 1);
                ps2_clk_in = 1'b1;
            end
        end
        wait_cyc(HALF);
        ps2_data_in = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic check_busy(input string name);
        bit exp_b;
        exp_b = (m_pause != 0) || m_ext || m_brk;
        @(negedge clk_sys);
        total++;
        if (busy !== exp_b) begin
            bad++;
            $display("FAIL %s busy got=%0b want=%0b", name, busy, exp_b);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                         input int glitch_at);
        model_frame(b, !(bad_par || bad_stop));
        send_bits(b, bad_par, bad_stop, 11, glitch_at);
        $display("frame %02h par_err=%0b stop_err=%0b -> key=%03h err_q=%0d busy=%0b",
                 b, bad_par, bad_stop, ps2_key, exp_q.size(), busy);
        check_busy($sformatf("busy_after_%02h", b));
    endtask

    task automatic check_val(input string name, input logic [10:0] got, input logic [10:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%03h want=%03h", name, got, want);
        end
    endtask

    // Monitor / scoreboard: every frame_err pulse or ps2_key change pops one entry.
    always @(negedge clk_sys) begin
        exp_t   e;
        longint dly;
        if (!reset_n) begin
            prev_key = '0;
        end else begin
            if (frame_err && (ps2_key != prev_key)) begin
                total++; bad++;
                $display("FAIL err_with_key key=%03h prev=%03h", ps2_key, prev_key);
            end
            if (frame_err || (ps2_key != prev_key)) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output err=%0b key=%03h", frame_err, ps2_key);
                end else begin
                    e = exp_q.pop_front();
                    if ((e.err != frame_err) || (!e.err && (ps2_key !== e.key))) begin
                        bad++;
                        $display("FAIL scoreboard got err=%0b key=%03h want err=%0b key=%03h",
                                 frame_err, ps2_key, e.err, e.key);
                    end else begin
                        $display("event err=%0b key=%03h ok", frame_err, ps2_key);
                    end
                end
                if (frame_err && check_to) begin
                    check_to = 1'b0;
                    dly = ($time - 5 - t_fall) / 10;
                    total++;
                    if (dly < TO + FL + 1 || dly > TO + FL + 3) begin
                        bad++;
                        $display("FAIL timeout_delay got=%0d want=%0d", dly, TO + FL + 2);
                    end
                end
            end
            prev_key = ps2_key;
        end
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int         r;
        bit         bp, bs;

        m_key = '0;
        model_clear();

        // Reset state.
        wait_cyc(3);
        @(negedge clk_sys);
        check_val("reset_key", ps2_key, 11'h000);
        check_val("reset_err", {10'd0, frame_err}, 11'h000);
        check_val("reset_busy", {10'd0, busy}, 11'h000);
        reset_n = 1'b1;
        wait_cyc(GAP);

        // Make / break.
        frame(8'h1C, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h1C, 0, 0, -1);
        // Extended make / break.
        frame(8'hE0, 0, 0, -1);
        frame(8'h75, 0, 0, -1);
        frame(8'hE0, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h75, 0, 0, -1);
        // Parity error then good key.
        frame(8'h1C, 1, 0, -1);
        frame(8'h29, 0, 0, -1);
        // Stop bit error.
        frame(8'h33, 0, 1, -1);

        // Timeout: start + 3 data bits, then clock idle.
        push_err();
        model_clear();
        check_to = 1'b1;
        send_bits(8'h5A, 0, 0, 4, -1);
        wait_cyc(TO + 2);
        check_busy("busy_after_timeout");
        frame(8'h1C, 0, 0, -1);

        // Glitch on the clock mid-frame.
        frame(8'h2B, 0, 0, 4);

        // Pause sequence.
        frame(8'hE1, 0, 0, -1);
        frame(8'h14, 0, 0, -1);
        frame(8'h77, 0, 0, -1);
        frame(8'hE1, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h14, 0, 0, -1);
        frame(8'hF0, 0, 0, -1);
        frame(8'h77, 0, 0, -1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = 8'hE1;
                3: rb = 8'hFA;
                default: rb = 8'($urandom_range(0, 255));
            endcase
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 14) == 0);
            frame(rb, bp, bs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1);
        end

        // Reset in the middle of a frame.
        send_bits(8'h74, 0, 0, 6, -1);
        @(posedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset key=%03h err=%0b busy=%0b", ps2_key, frame_err, busy);
        check_val("async_reset_key", ps2_key, 11'h000);
        check_val("async_reset_err", {10'd0, frame_err}, 11'h000);
        check_val("async_reset_busy", {10'd0, busy}, 11'h000);
        m_key = '0;
        model_clear();
        exp_q.delete();
        wait_cyc(3);
        reset_n = 1'b1;
        wait_cyc(GAP);
        frame(8'h74, 0, 0, -1);
        check_val("key_after_reset", ps2_key, 11'h674);

        wait_cyc(GAP);
        @(negedge clk_sys);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_outputs got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
